uart_tx_arbiter: RTL and testbench
==================================

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter CLKS_PER_BIT, default 868: clocks per serial bit; SHALL be legal for values 2..65535.
REQ-002 Parameter STOP_BITS, default 1: number of stop bits; SHALL be legal for values 1 and 2.
REQ-003 i_clk  in  1  sole clock; all logic SHALL be on its rising edge.
REQ-004 i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 i_req  in  4  per-requester send request; bit k belongs to requester k.
REQ-006 i_data  in  32  requester k byte on bits [8k+7:8k].
REQ-007 o_ack  out  4  one-hot, single-cycle pulse: byte of requester k accepted.
REQ-008 o_grant_id  out  2  index of the requester whose frame is in flight.
REQ-009 o_busy  out  1  high while a frame is being transmitted.
REQ-010 o_frame_done  out  1  single-cycle pulse at frame end.
REQ-011 o_tx  out  1  serial line; idle level is 1.

Function
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP.
REQ-013 In IDLE, when any i_req bit is high, the FSM SHALL select one requester by round-robin, starting the search at the pointer and moving upward modulo 4.
REQ-014 On the edge following that IDLE cycle, the FSM SHALL:
- latch the selected byte;
- set o_grant_id;
- pulse the matching o_ack bit for exactly one cycle;
- drive o_tx to 0;
- enter START.
REQ-015 The pointer SHALL become (granted index + 1) mod 4 at grant time.
REQ-016 Each bit period SHALL hold o_tx stable for exactly CLKS_PER_BIT cycles.
REQ-017 Bit periods SHALL be timed by a counter that clears at every state or bit change.
REQ-018 START SHALL last one bit period.
REQ-019 DATA SHALL send 8 bits, LSB first, one bit period each.
REQ-020 STOP SHALL drive o_tx=1 for STOP_BITS bit periods.
REQ-021 Total frame length SHALL be (9+STOP_BITS)*CLKS_PER_BIT cycles, counted from the o_ack cycle.
REQ-022 o_frame_done SHALL pulse in the last cycle of STOP, and the FSM SHALL then enter IDLE.
REQ-023 IDLE SHALL last at least one cycle, giving a minimum inter-frame mark gap of 1 clock.
REQ-024 o_busy SHALL be 1 in START, DATA and STOP, and 0 in IDLE.
REQ-025 A requester SHALL hold i_req and its data until o_ack; a request still high in the next IDLE cycle is served again as a new frame.
REQ-026 i_req and i_data changes during START, DATA or STOP SHALL have no effect on the frame in flight.
REQ-027 Deasserting i_req before ack SHALL withdraw the request with no side effect.
REQ-028 With all four requesters requesting continuously, each requester SHALL be granted once per 4 frames, in order k, k+1, k+2, k+3.
REQ-029 o_grant_id SHALL hold its value through IDLE until the next grant.

Reset
REQ-030 When i_rst_n=0 at a rising edge, the following SHALL take effect on that edge regardless of current state:
- state=IDLE;
- o_tx=1;
- o_ack=0, o_busy=0, o_frame_done=0;
- o_grant_id=0;
- pointer=0 (requester 0 highest priority);
- bit counter, bit index and data latch cleared.
REQ-031 A frame interrupted by reset SHALL be abandoned and not resumed.
REQ-032 Arbitration SHALL resume on the first cycle with i_rst_n=1.

Structure
REQ-033 Shared package uart_pkg SHALL hold:
- the FSM state encoding;
- N_REQ=4;
- DATA_BITS=8.
REQ-034 Bit-period timing SHALL live in sub-module uart_baud_gen (inputs clear and enable; output one-cycle tick every CLKS_PER_BIT cycles), instantiated once.
REQ-035 All outputs SHALL be registered.

Verification (CLKS_PER_BIT=4, STOP_BITS=1 unless stated)
REQ-036 i_req=0001, byte 0x55 -> o_ack=0001 for one cycle; o_tx sequence 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles; o_frame_done pulses at cycle 40; o_busy=1 for cycles 1..40.
REQ-037 i_req=1111 held continuously -> o_grant_id sequence 0,1,2,3,0 across 5 frames; frame starts exactly 41 cycles apart.
REQ-038 i_req=0100 granted, then i_req=0101 raised during frame -> next grant is 3? no; pointer=3 so search order 3,0,1,2 -> requester 0 granted, then requester 2.
REQ-039 Reset asserted mid-DATA (cycle 18) -> o_tx=1, o_busy=0, o_grant_id=0 after that edge; a pending request with i_req=1000 gets its o_ack 1 cycle after reset release.
REQ-040 STOP_BITS=2, byte 0xA3 -> frame length 44 cycles; stop level held 8 cycles; i_data change mid-frame does not alter the transmitted bits.
REQ-041 i_req=0010 dropped before ack (while busy) -> no o_ack[1] ever, line stays idle after current frame.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   N_REQ      - number of requesters sharing the serial line
//   DATA_BITS  - payload bits per frame
//   tx_state_e - transmit FSM state encoding
//   rr_pick    - round-robin selection starting at a pointer, moving upward mod N_REQ
package uart_pkg;

    localparam int unsigned N_REQ     = 4;
    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } tx_state_e;

    // Returns the first requester at or above ptr (wrapping) whose request bit is set.
    // Scans from the farthest offset down so the nearest hit is the one that sticks.
    function automatic logic [1:0] rr_pick(input logic [1:0] ptr, input logic [N_REQ-1:0] req);
        logic [1:0] idx;
        rr_pick = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = ptr + 2'(i);
            if (req[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer for the UART transmitter.
//   i_clk      - clock
//   i_rst_n    - synchronous active-low reset
//   i_clear    - forces the counter to zero (held while the line is idle)
//   i_enable   - counts while high
//   o_tick     - high in the last cycle of each CLKS_PER_BIT-cycle period
//   o_pre_tick - high in the cycle before o_tick, for registering end-of-period outputs
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tick,
    output logic o_pre_tick
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign o_tick     = i_enable && !i_clear && (cnt_q == CntW'(CLKS_PER_BIT - 1));
    assign o_pre_tick = i_enable && !i_clear && (cnt_q == CntW'(CLKS_PER_BIT - 2));

    // Wrapping on the tick restarts the period at every bit or state change.
    always_comb begin
        cnt_d = cnt_q;
        if (i_clear || o_tick) begin
            cnt_d = '0;
        end else if (i_enable) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Four-requester UART transmitter with round-robin arbitration.
//   i_clk        - clock
//   i_rst_n      - synchronous active-low reset
//   i_req        - per-requester send request
//   i_data       - requester k byte on [8k+7:8k]
//   o_ack        - one-cycle one-hot pulse when a requester's byte is accepted
//   o_grant_id   - requester whose frame is (or was last) in flight
//   o_busy       - high while a frame is on the line
//   o_frame_done - one-cycle pulse in the last cycle of the frame
//   o_tx         - serial output, idle high, 8N1 / 8N2
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 868,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [N_REQ-1:0]             i_req,
    input  logic [N_REQ*DATA_BITS-1:0]   i_data,
    output logic [N_REQ-1:0]             o_ack,
    output logic [1:0]                   o_grant_id,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_tx
);

    tx_state_e            state_q, state_d;
    logic [1:0]           ptr_q, ptr_d;
    logic [1:0]           grant_q, grant_d;
    logic [N_REQ-1:0]     ack_q, ack_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic [2:0]           bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;

    logic       tick, pre_tick, stop_last;
    logic [1:0] pick;

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (state_q == StIdle),
        .i_enable  (state_q != StIdle),
        .o_tick    (tick),
        .o_pre_tick(pre_tick)
    );

    assign pick      = rr_pick(ptr_q, i_req);
    assign stop_last = (stop_idx_q == 1'(STOP_BITS - 1));

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        ack_d      = '0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tx_d       = tx_q;
        data_d     = data_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        unique case (state_q)
            StIdle: begin
                if (|i_req) begin
                    state_d     = StStart;
                    grant_d     = pick;
                    ack_d[pick] = 1'b1;
                    ptr_d       = pick + 2'd1;
                    data_d      = i_data[DATA_BITS*int'(pick) +: DATA_BITS];
                    tx_d        = 1'b0;
                    busy_d      = 1'b1;
                    bit_idx_d   = '0;
                    stop_idx_d  = 1'b0;
                end
            end
            StStart: begin
                if (tick) begin
                    state_d = StData;
                    tx_d    = data_q[0];
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_idx_q == 3'(DATA_BITS - 1)) begin
                        state_d = StStop;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = data_q[bit_idx_q + 3'd1];
                    end
                end
            end
            StStop: begin
                // Registered done must already be set in the final cycle, so arm it one early.
                if (pre_tick && stop_last) begin
                    done_d = 1'b1;
                end
                if (tick) begin
                    if (stop_last) begin
                        state_d = StIdle;
                        busy_d  = 1'b0;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= StIdle;
            ptr_q      <= '0;
            grant_q    <= '0;
            ack_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            tx_q       <= 1'b1;
            data_q     <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            ack_q      <= ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            tx_q       <= tx_d;
            data_q     <= data_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
        end
    end

    assign o_ack        = ack_q;
    assign o_grant_id   = grant_q;
    assign o_busy       = busy_q;
    assign o_frame_done = done_q;
    assign o_tx         = tx_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: CLKS_PER_BIT=4, one instance per stop-bit setting.
// Inputs change and outputs are sampled on the falling edge.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req, req2;
    logic [31:0] data, data2;
    logic [3:0]  ack, ack2;
    logic [1:0]  grant, grant2;
    logic        busy, busy2, done, done2, tx, tx2;

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] tx_v, busy_v, done_v, ack_v;
    logic [3:0]  ack1;
    logic [1:0]  grant1;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_data(data), .o_ack(ack),
        .o_grant_id(grant), .o_busy(busy), .o_frame_done(done), .o_tx(tx)
    );

    uart_tx_arbiter #(.CLKS_PER_BIT(4), .STOP_BITS(2)) dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_data(data2), .o_ack(ack2),
        .o_grant_id(grant2), .o_busy(busy2), .o_frame_done(done2), .o_tx(tx2)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line level per cycle of a frame (bit 0 = ack cycle), 4 clocks per bit.
    function automatic logic [63:0] exp_tx(input logic [7:0] b, input int sb);
        logic [63:0] v;
        int p;
        v = '0;
        for (int c = 0; c < (9 + sb) * 4; c++) begin
            p = c / 4;
            if (p == 0)      v[c] = 1'b0;
            else if (p <= 8) v[c] = b[p-1];
            else             v[c] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [63:0] ones(input int n);
        return (64'd1 << n) - 64'd1;
    endfunction

    // Call on the negedge where the request was driven; records cycles 1..n of the frame.
    task automatic watch(input bit sel, input int n, input logic [3:0] drop, input bit mut);
        tx_v = '0; busy_v = '0; done_v = '0; ack_v = '0;
        for (int c = 1; c <= n; c++) begin
            @(negedge clk);
            tx_v[c-1]   = sel ? tx2 : tx;
            busy_v[c-1] = sel ? busy2 : busy;
            done_v[c-1] = sel ? done2 : done;
            ack_v[c-1]  = sel ? |ack2 : |ack;
            if (c == 1) begin
                ack1   = sel ? ack2 : ack;
                grant1 = sel ? grant2 : grant;
                if (sel) req2 = req2 & ~drop;
                else     req  = req & ~drop;
            end
            if (mut && c == 10) begin
                if (sel) data2 = ~data2;
                else     data  = ~data;
            end
        end
    endtask

    task automatic wait_ack(output logic [3:0] a, output logic [1:0] g, output int cyc);
        a = '0; g = '0; cyc = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge clk);
            if (ack != 4'b0) begin
                a = ack; g = grant; cyc = i;
                break;
            end
        end
        if (cyc == 0) check_eq("ack_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_idle();
        int ok;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        if (ok == 0) check_eq("idle_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a;
        logic [1:0] g;
        int         cyc;
        logic [1:0] exp_g [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        int         acks;

        rst_n = 1'b0; req = '0; req2 = '0; data = '0; data2 = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_tx", tx, 1);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ack", ack, 0);
        check_eq("rst_grant", grant, 0);
        check_eq("rst_done", done, 0);
        rst_n = 1'b1;

        // Single frame, byte 0x55 from requester 0; other lanes carry noise.
        req  = 4'b0001;
        data = 32'h1234_5655;
        watch(1'b0, 40, 4'b0001, 1'b0);
        check_eq("f1_ack", ack1, 4'b0001);
        check_eq("f1_grant", grant1, 0);
        check_eq("f1_ack_once", ack_v, 64'd1);
        check_eq("f1_tx", tx_v, exp_tx(8'h55, 1));
        check_eq("f1_busy", busy_v, ones(40));
        check_eq("f1_done", done_v, 64'd1 << 39);
        @(negedge clk);
        check_eq("f1_idle_busy", busy, 0);
        check_eq("f1_idle_tx", tx, 1);
        check_eq("f1_idle_done", done, 0);

        // Reset, then all four requesting continuously.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req   = 4'b1111;
        data  = 32'hC3A5_5A3C;
        for (int k = 0; k < 5; k++) begin
            wait_ack(a, g, cyc);
            check_eq($sformatf("rr_grant%0d", k), g, exp_g[k]);
            check_eq($sformatf("rr_ack%0d", k), a, 4'b0001 << exp_g[k]);
            check_eq($sformatf("rr_gap%0d", k), cyc, (k == 0) ? 1 : 41);
        end
        req = 4'b0;

        // Requester 2 granted, then 0 and 2 compete: pointer at 3 favours 0.
        req = 4'b0100;
        wait_ack(a, g, cyc);
        check_eq("p38_a_ack", a, 4'b0100);
        check_eq("p38_a_gap", cyc, 41);
        req = 4'b0101;
        wait_ack(a, g, cyc);
        check_eq("p38_b_ack", a, 4'b0001);
        check_eq("p38_b_grant", g, 0);
        req = 4'b0100;
        wait_ack(a, g, cyc);
        check_eq("p38_c_ack", a, 4'b0100);
        check_eq("p38_c_grant", g, 2);
        req = 4'b0;
        wait_idle();
        check_eq("grant_hold", grant, 2);

        // Reset in the middle of DATA, with requester 3 waiting.
        req  = 4'b0010;
        data = 32'h8100_3C00;
        wait_ack(a, g, cyc);
        check_eq("r39_ack", a, 4'b0010);
        req = 4'b0;
        repeat (17) @(negedge clk);
        check_eq("r39_busy_pre", busy, 1);
        rst_n = 1'b0;
        req   = 4'b1000;
        @(negedge clk);
        check_eq("r39_tx", tx, 1);
        check_eq("r39_busy", busy, 0);
        check_eq("r39_grant", grant, 0);
        check_eq("r39_ack", ack, 0);
        rst_n = 1'b1;
        wait_ack(a, g, cyc);
        check_eq("r39_new_ack", a, 4'b1000);
        check_eq("r39_new_grant", g, 3);
        check_eq("r39_new_lat", cyc, 1);
        req = 4'b0;
        wait_idle();

        // Requester 1 raises then withdraws while the line is busy.
        req  = 4'b0001;
        data = 32'h0000_F00F;
        wait_ack(a, g, cyc);
        req = 4'b0;
        repeat (4) @(negedge clk);
        req = 4'b0010;
        repeat (15) @(negedge clk);
        check_eq("w41_busy_mid", busy, 1);
        req  = 4'b0;
        acks = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ack != 4'b0) acks++;
        end
        check_eq("w41_no_ack", acks, 0);
        check_eq("w41_busy", busy, 0);
        check_eq("w41_tx", tx, 1);

        // Two stop bits, byte 0xA3 on lane 2, data scrambled mid-frame.
        req2  = 4'b0100;
        data2 = 32'h11A3_2233;
        watch(1'b1, 44, 4'b0100, 1'b1);
        check_eq("s2_ack", ack1, 4'b0100);
        check_eq("s2_grant", grant1, 2);
        check_eq("s2_tx", tx_v, exp_tx(8'hA3, 2));
        check_eq("s2_busy", busy_v, ones(44));
        check_eq("s2_done", done_v, 64'd1 << 43);
        @(negedge clk);
        check_eq("s2_idle_busy", busy2, 0);
        check_eq("s2_idle_tx", tx2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
